// File: rtl/i2c_slave_sync_if.sv
// Pad-side and byte-handshake signals of the clocked I2C target.
// The slave modport is the target's view; the master modport is the pad/host side.
interface i2c_slave_sync_if;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ack;
  logic       addressed;
  logic       rw;
  logic       stop_det;
  logic       nack_det;

  modport slave (
    input  scl_i, sda_i, rx_ready, tx_data, tx_valid,
    output scl_oe, sda_oe, rx_data, rx_valid, tx_ack, addressed, rw, stop_det, nack_det
  );

  modport master (
    output scl_i, sda_i, rx_ready, tx_data, tx_valid,
    input  scl_oe, sda_oe, rx_data, rx_valid, tx_ack, addressed, rw, stop_det, nack_det
  );
endinterface

// File: rtl/i2c_slave_sync.sv
// Clocked I2C target: synchronised and glitch-filtered SCL/SDA, 7-bit address match,
// byte valid/ready handshake for write and read data, optional SCL stretching.
module i2c_slave_sync #(
  parameter logic [6:0]  ADDR       = 7'h2A,
  parameter int unsigned FILT_LEN   = 3,
  parameter bit          STRETCH_EN = 1'b1,
  parameter logic [7:0]  TX_IDLE    = 8'hFF
) (
  input logic             clk,
  input logic             rst_n,
  i2c_slave_sync_if.slave bus
);
  // state     | meaning
  // IDLE      | wait START          ADDR    | shift address byte
  // ADDR_ACK  | drive address ACK   RX_BYTE | shift write byte      RX_ACK | drive ACK/NACK
  // TX_LOAD   | fetch read byte     TX_BYTE | drive read byte       TX_ACK | sample master ACK
  // WAIT_STOP | ignore bus until STOP/START
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK,
    S_TX_LOAD, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
  } state_t;

  localparam logic [2:0] FILT_TC = 3'(FILT_LEN - 1);

  // index 0 = SCL, index 1 = SDA
  logic [1:0] s1_q, s2_q, f_q, f_d, fp_q;
  logic [2:0] fcnt_q [2];
  logic [2:0] fcnt_d [2];

  always_comb begin
    f_d = f_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (fcnt_q[i] == FILT_TC) f_d[i] = s2_q[i];
        else                      fcnt_d[i] = fcnt_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      f_q    <= 2'b11;
      fp_q   <= 2'b11;
      fcnt_q <= '{default: '0};
    end else begin
      s1_q   <= {bus.sda_i, bus.scl_i};
      s2_q   <= s1_q;
      f_q    <= f_d;
      fp_q   <= f_q;
      fcnt_q <= fcnt_d;
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_f    = f_q[0];
  assign sda_f    = f_q[1];
  assign scl_rise = f_q[0] & ~fp_q[0];
  assign scl_fall = ~f_q[0] & fp_q[0];
  assign start_ev = f_q[0] & fp_q[0] & fp_q[1] & ~f_q[1];
  assign stop_ev  = f_q[0] & fp_q[0] & ~fp_q[1] & f_q[1];

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, rx_data_q, rx_data_d, load_byte;
  logic       phase_q, phase_d, ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic       rx_valid_q, rx_valid_d, tx_ack_q, tx_ack_d;
  logic       addressed_q, addressed_d, rw_q, rw_d;
  logic       stop_det_q, stop_det_d, nack_det_q, nack_det_d;

  assign load_byte = bus.tx_valid ? bus.tx_data : TX_IDLE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    phase_d     = phase_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    stop_det_d  = 1'b0;
    nack_det_d  = 1'b0;
    if (start_ev) begin
      state_d     = S_ADDR;
      cnt_d       = 3'd7;
      phase_d     = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_ev) begin
      state_d     = S_IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_det_d  = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          sh_d  = {sh_q[6:0], sda_f};
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            if (sh_q[6:0] == ADDR) begin
              state_d = S_ADDR_ACK;
              rw_d    = sda_f;
              phase_d = 1'b0;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d    = 1'b1;
            addressed_d = 1'b1;
            phase_d     = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            cnt_d    = 3'd7;
            state_d  = rw_q ? S_TX_LOAD : S_RX_BYTE;
          end
        end
        S_RX_BYTE: if (scl_rise) begin
          sh_d  = {sh_q[6:0], sda_f};
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            rx_data_d  = {sh_q[6:0], sda_f};
            rx_valid_d = 1'b1;
            ack_d      = bus.rx_ready;
            phase_d    = 1'b0;
            state_d    = S_RX_ACK;
          end
        end
        S_RX_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = ack_q;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = ack_q ? S_RX_BYTE : S_WAIT_STOP;
          end
        end
        // first bit goes out while SCL is low; SCL is let go one clk later so SDA leads it
        S_TX_LOAD: if (!scl_f) begin
          if (bus.tx_valid || !STRETCH_EN) begin
            sh_d     = load_byte;
            sda_oe_d = ~load_byte[7];
            tx_ack_d = bus.tx_valid;
            scl_oe_d = scl_oe_q;
            cnt_d    = 3'd7;
            state_d  = S_TX_BYTE;
          end else begin
            scl_oe_d = 1'b1;
          end
        end
        S_TX_BYTE: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = S_TX_ACK;
          end else begin
            sh_d     = {sh_q[6:0], 1'b0};
            sda_oe_d = ~sh_q[6];
            cnt_d    = cnt_q - 3'd1;
          end
        end
        S_TX_ACK: begin
          if (scl_rise && !phase_q) begin
            if (sda_f) begin
              nack_det_d = 1'b1;
              state_d    = S_WAIT_STOP;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            phase_d = 1'b0;
            state_d = S_TX_LOAD;
          end
        end
        S_IDLE, S_WAIT_STOP: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd7;
      sh_q        <= '0;
      phase_q     <= 1'b0;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      stop_det_q  <= 1'b0;
      nack_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      phase_q     <= phase_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ack_q    <= tx_ack_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      stop_det_q  <= stop_det_d;
      nack_det_q  <= nack_det_d;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_ack    = tx_ack_q;
  assign bus.addressed = addressed_q;
  assign bus.rw        = rw_q;
  assign bus.stop_det  = stop_det_q;
  assign bus.nack_det  = nack_det_q;
endmodule

// File: tb/tb_i2c_slave_sync.sv
// Bench for i2c_slave_sync: a bit-banged bus master over open-drain wires, with a
// transaction-level model of which bytes the target should ACK, deliver and return.
`timescale 1ns/1ps
module tb_i2c_slave_sync;
  localparam int         Q   = 8;
  localparam logic [6:0] SLV = 7'h2A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1, sda_m = 1'b1, scl_gl = 1'b0;
  logic       rx_ready = 1'b1, tx_hold = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  i2c_slave_sync_if ifc ();
  assign ifc.scl_i    = (scl_m & ~ifc.scl_oe) ^ scl_gl;
  assign ifc.sda_i    = sda_m & ~ifc.sda_oe;
  assign ifc.rx_ready = rx_ready;
  assign ifc.tx_data  = tx_data;
  assign ifc.tx_valid = tx_valid;

  i2c_slave_sync #(.ADDR(SLV), .FILT_LEN(3), .STRETCH_EN(1'b1), .TX_IDLE(8'hFF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  int n_txack = 0, n_stop = 0, n_nack = 0, n_sda_oe = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.rx_valid) rx_got.push_back(ifc.rx_data);
      if (ifc.tx_ack)   n_txack++;
      if (ifc.stop_det) n_stop++;
      if (ifc.nack_det) n_nack++;
      if (ifc.sda_oe)   n_sda_oe++;
    end
  end

  // read-data source: presents the head of tx_q, pops it when the target acknowledges the load
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ifc.tx_ack && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_valid = !tx_hold && (tx_q.size() > 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (ifc.scl_i) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("scl_high_timeout", ok, 1);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(2*Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    b = ifc.sda_i; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    sda_m = 1'b1; tick(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i]);
      if (glitch) begin
        scl_gl = 1'b1; tick(1); scl_gl = 1'b0;
      end
    end
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // Model: the target ACKs while it is addressed and every earlier byte was accepted;
  // each byte reaching it is delivered on rx, and it goes deaf after the first refusal.
  task automatic do_write(input logic [6:0] a, input logic [7:0] d[$], input bit rdy[$], input string tag);
    logic ack;
    bit live;
    logic [7:0] exp_rx[$];
    int rx_base, stop_base, oe_base;
    rx_base = rx_got.size(); stop_base = n_stop; oe_base = n_sda_oe;
    i2c_start();
    send_byte({a, 1'b0}, 1'b0, ack);
    live = (a == SLV);
    check({tag, "_addr_ack"}, ack, !live);
    check({tag, "_addressed"}, ifc.addressed, live);
    if (live) check({tag, "_rw"}, ifc.rw, 0);
    foreach (d[i]) begin
      rx_ready = rdy[i];
      send_byte(d[i], 1'b0, ack);
      check($sformatf("%s_data_ack%0d", tag, i), ack, !(live && rdy[i]));
      if (live) exp_rx.push_back(d[i]);
      live = live && rdy[i];
    end
    rx_ready = 1'b1;
    i2c_stop();
    tick(4);
    if (a != SLV) check({tag, "_sda_oe_cycles"}, n_sda_oe - oe_base, 0);
    check({tag, "_rx_count"}, rx_got.size() - rx_base, exp_rx.size());
    foreach (exp_rx[i])
      if (rx_base + i < rx_got.size())
        check($sformatf("%s_rx%0d", tag, i), rx_got[rx_base + i], exp_rx[i]);
    check({tag, "_stop_det"}, n_stop - stop_base, 1);
  endtask

  task automatic do_read(input logic [7:0] d[$], input bit glitch, input string tag);
    logic ack;
    logic [7:0] got;
    int tx_base, nack_base, stop_base;
    tx_base = n_txack; nack_base = n_nack; stop_base = n_stop;
    foreach (d[i]) tx_q.push_back(d[i]);
    i2c_start();
    send_byte({SLV, 1'b1}, glitch, ack);
    check({tag, "_addr_ack"}, ack, 0);
    check({tag, "_rw"}, ifc.rw, 1);
    check({tag, "_addressed"}, ifc.addressed, 1);
    foreach (d[i]) begin
      recv_byte(i == d.size() - 1, got);
      check($sformatf("%s_byte%0d", tag, i), got, d[i]);
    end
    i2c_stop();
    tick(4);
    check({tag, "_tx_ack"}, n_txack - tx_base, d.size());
    check({tag, "_nack_det"}, n_nack - nack_base, 1);
    check({tag, "_stop_det"}, n_stop - stop_base, 1);
    tx_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wq[$];
    bit         wr[$];
    logic       ack;
    logic [7:0] got;
    logic [6:0] a;
    int         tx_base, nack_base, rx_base, lowcnt, len;
    bit         ok;

    rst_n = 1'b0;
    tick(5);
    check("reset_flags", {ifc.scl_oe, ifc.sda_oe, ifc.rx_valid, ifc.tx_ack, ifc.addressed,
                          ifc.rw, ifc.stop_det, ifc.nack_det}, 0);
    check("reset_rx_data", ifc.rx_data, 0);
    rst_n = 1'b1;
    tick(10);

    wq.delete(); wr.delete();
    wq.push_back(8'hA5); wr.push_back(1'b1);
    wq.push_back(8'h3C); wr.push_back(1'b1);
    do_write(SLV, wq, wr, "t1");

    wq.delete(); wr.delete();
    wq.push_back(8'h11); wr.push_back(1'b1);
    do_write(7'h2B, wq, wr, "t2");

    wq.delete();
    wq.push_back(8'h81); wq.push_back(8'hC3);
    do_read(wq, 1'b0, "t3");

    // stretch while the read byte is withheld
    tx_base = n_txack; nack_base = n_nack;
    tx_hold = 1'b1;
    tx_q.push_back(8'h5A);
    i2c_start();
    send_byte({SLV, 1'b1}, 1'b0, ack);
    check("t4_addr_ack", ack, 0);
    tick(Q);
    scl_m = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (!ifc.scl_oe || ifc.scl_i) lowcnt++;
    end
    check("t4_stretch_hold", lowcnt, 0);
    scl_m = 1'b0;
    tx_hold = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("t4_tx_valid_seen", ok, 1);
    tick(2);
    check("t4_stretch_release", ifc.scl_oe, 0);
    recv_byte(1'b1, got);
    check("t4_byte", got, 8'h5A);
    i2c_stop();
    tick(4);
    check("t4_tx_ack", n_txack - tx_base, 1);
    check("t4_nack_det", n_nack - nack_base, 1);
    tx_q.delete();

    wq.delete(); wr.delete();
    wq.push_back(8'hA5); wr.push_back(1'b0);
    wq.push_back(8'h3C); wr.push_back(1'b1);
    do_write(SLV, wq, wr, "t5");

    // repeated START after a partial write byte, then a glitchy read address
    rx_base = rx_got.size();
    i2c_start();
    send_byte({SLV, 1'b0}, 1'b0, ack);
    check("t6_wr_addr_ack", ack, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    wq.delete();
    wq.push_back(8'h77);
    do_read(wq, 1'b1, "t6");
    check("t6_no_rx", rx_got.size() - rx_base, 0);

    // reset in the middle of a stretched read
    tx_hold = 1'b1;
    tx_q.push_back(8'h99);
    i2c_start();
    send_byte({SLV, 1'b1}, 1'b0, ack);
    tick(2*Q);
    check("rst_pre_stretch", ifc.scl_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_release", {ifc.scl_oe, ifc.sda_oe, ifc.addressed}, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    tx_q.delete();
    tx_hold = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(10);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) a = SLV;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == SLV) a = a ^ 7'h01;
      end
      len = $urandom_range(1, 3);
      wq.delete(); wr.delete();
      for (int i = 0; i < len; i++) begin
        wq.push_back(8'($urandom_range(0, 255)));
        wr.push_back($urandom_range(0, 3) != 0);
      end
      do_write(a, wq, wr, $sformatf("rw%0d", t));
    end

    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 3);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom_range(0, 255)));
      do_read(wq, 1'b0, $sformatf("rr%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
